// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// FSM states and the iteration counter width.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Counter must hold 0..width-1; one spare bit keeps width=1 legal.
  function automatic int mdu_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_w(32);

endpackage

// File: rtl/mdu_step.sv
// One unsigned iteration: shift-add multiply step or restoring divide step
// on the packed {upper, lower} accumulator.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_shift;
  logic [WIDTH:0]   w_trial;

  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
              (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_shift = {i_acc, 1'b0};
    w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, i_opnd};
    o_acc   = {w_sum, i_acc[WIDTH-1:1]};
    // Divide: a clear borrow bit means the trial subtraction fits, so keep it.
    if (i_is_div) begin
      if (!w_trial[WIDTH])
        o_acc = {w_trial[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};
      else
        o_acc = w_shift[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit: WIDTH unsigned iterations
// on operand magnitudes, then a sign-fix cycle that writes Hi/Lo.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Mdu_start,
  input  logic [1:0]       Mdu_op,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             Mthi,
  input  logic             Mtlo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = mdu_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_e         r_state, w_next_state;
  mdu_op_e            r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step_acc, w_prod;
  logic [WIDTH-1:0]   r_opnd, r_rs;
  logic               r_neg_res, r_neg_rem, r_div_zero, r_busy, r_done;
  logic               w_signed, w_rs_neg, w_rt_neg, w_is_div;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag, w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_signed = ~Mdu_op[0];
  assign w_rs_neg = w_signed & Read_data_1[WIDTH-1];
  assign w_rt_neg = w_signed & Read_data_2[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -Read_data_1 : Read_data_1;
  assign w_rt_mag = w_rt_neg ? -Read_data_2 : Read_data_2;
  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (r_state == ST_FIX);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (Mdu_start) w_next_state = ST_RUN;
      ST_RUN:  if (r_cnt == LAST_ITER) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op       <= OP_MULT;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_rs       <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (r_state == ST_IDLE && Mdu_start) begin
      r_op       <= mdu_op_e'(Mdu_op);
      r_cnt      <= '0;
      r_acc      <= {{WIDTH{1'b0}}, (Mdu_op[1] ? w_rs_mag : w_rt_mag)};
      r_opnd     <= Mdu_op[1] ? w_rt_mag : w_rs_mag;
      r_rs       <= Read_data_1;
      r_neg_res  <= w_rs_neg ^ w_rt_neg;
      r_neg_rem  <= w_rs_neg;
      r_div_zero <= Mdu_op[1] && (Read_data_2 == '0);
    end else if (r_state == ST_RUN) begin
      r_acc <= w_step_acc;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      w_res_hi = r_div_zero ? r_rs : w_rem;
      w_res_lo = r_div_zero ? {WIDTH{1'b1}} : w_quo;
    end
  end

  // Mthi/Mtlo only land while idle; the FIX write wins over everything else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (r_state == ST_FIX) begin
      Hi <= w_res_hi;
      Lo <= w_res_lo;
    end else if (r_state == ST_IDLE) begin
      if (Mthi) Hi <= Read_data_1;
      if (Mtlo) Lo <= Read_data_1;
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;

endmodule
